clock_set_ctrl: RTL

Time-keeping and time-setting controller for the digital clock. It consumes single-cycle pulses from the push-button debouncers and a 1 Hz strobe, and sequences the clock through run, set-hours and set-minutes modes. It owns the hours/minutes/seconds registers and produces the field-blink enables for the 7-segment display driver. It sits between the debouncer bank and the display multiplexer.

---
 rtl/clock_set_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/clock_set_ctrl.sv
// Time-keeping and time-setting controller: owns the hh:mm:ss registers,
// sequences RUN / SET_HR / SET_MIN from button pulses and drives the field-blink enables.
module clock_set_ctrl #(
  parameter int BLINK_DIV = 50000000,
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       mode_p,
  input  logic       up_p,
  input  logic       down_p,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       hr_on,
  output logic       min_on
);

  localparam int IDLE_W  = $clog2(TIMEOUT_S + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  localparam logic [IDLE_W-1:0]  IDLE_LIMIT = IDLE_W'(TIMEOUT_S);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_t;

  mode_t               mode_q, mode_d;
  logic [4:0]          hours_q, hours_d;
  logic [5:0]          minutes_q, minutes_d;
  logic [5:0]          seconds_q, seconds_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic                hr_on_q, hr_on_d;
  logic                min_on_q, min_on_d;

  logic                activity;
  logic                inc_only;
  logic                dec_only;
  logic [IDLE_W-1:0]   idle_inc;

  // up and down together cancel out but still count as activity
  assign activity = mode_p | up_p | down_p;
  assign inc_only = up_p & ~down_p;
  assign dec_only = down_p & ~up_p;
  assign idle_inc = idle_q + IDLE_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= RUN;
      hours_q     <= '0;
      minutes_q   <= '0;
      seconds_q   <= '0;
      idle_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      hr_on_q     <= 1'b1;
      min_on_q    <= 1'b1;
    end else begin
      mode_q      <= mode_d;
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      seconds_q   <= seconds_d;
      idle_q      <= idle_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      hr_on_q     <= hr_on_d;
      min_on_q    <= min_on_d;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    idle_d    = idle_q;

    unique case (mode_q)
      RUN: begin
        idle_d = '0;
        if (tick_1hz) begin
          if (seconds_q == 6'd59) begin
            seconds_d = '0;
            if (minutes_q == 6'd59) begin
              minutes_d = '0;
              hours_d   = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
            end else begin
              minutes_d = minutes_q + 6'd1;
            end
          end else begin
            seconds_d = seconds_q + 6'd1;
          end
        end
        if (mode_p) begin
          mode_d = SET_HR;
        end
      end

      SET_HR, SET_MIN: begin
        if (mode_p) begin
          if (mode_q == SET_HR) begin
            mode_d = SET_MIN;
          end else begin
            mode_d    = RUN;
            seconds_d = '0;
          end
        end else if (mode_q == SET_HR) begin
          if (inc_only) begin
            hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
          end else if (dec_only) begin
            hours_d = (hours_q == 5'd0) ? 5'd23 : hours_q - 5'd1;
          end
        end else begin
          if (inc_only) begin
            minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
          end else if (dec_only) begin
            minutes_d = (minutes_q == 6'd0) ? 6'd59 : minutes_q - 6'd1;
          end
        end

        // Activity outranks a coincident tick, so the idle count never reaches the limit then
        if (activity) begin
          idle_d = '0;
        end else if (tick_1hz) begin
          if (idle_inc == IDLE_LIMIT) begin
            idle_d = '0;
            mode_d = RUN;
          end else begin
            idle_d = idle_inc;
          end
        end
      end

      default: begin
        mode_d = RUN;
        idle_d = '0;
      end
    endcase
  end

  // Blink timing restarts on every mode change so the new field starts visible
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (mode_d != mode_q) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
  end

  always_comb begin
    hr_on_d  = !((mode_d == SET_HR) && !phase_d);
    min_on_d = !((mode_d == SET_MIN) && !phase_d);
  end

  assign hours   = hours_q;
  assign minutes = minutes_q;
  assign seconds = seconds_q;
  assign mode    = mode_q;
  assign hr_on   = hr_on_q;
  assign min_on  = min_on_q;

endmodule
